// File: rtl/shot_pkg.sv
// Shared definitions for the shot-clock controller.
//   shot_state_e : 3-bit FSM state encoding (also exported on the debug port)
package shot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_BUZZ    = 3'd3,
        ST_EXPIRED = 3'd4
    } shot_state_e;

endpackage

// File: rtl/shot_tick_gen.sv
// Prescaler producing one terminal-count pulse every TICK_DIV enabled cycles.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en_i     : advance the prescaler this cycle
//   clr_i    : return the prescaler to 0 (wins over en_i)
//   tc_o     : high in the enabled cycle whose edge wraps the prescaler to 0
// The prescaler value is held whenever en_i is low, so a paused partial tick
// resumes where it left off.
module shot_tick_gen #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;

    assign tc_o = en_i && (presc_q == LAST);

    always_comb begin
        presc_d = presc_q;
        if (clr_i) begin
            presc_d = '0;
        end else if (en_i) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot-clock controller: counts down from a reload value once per prescaled
// tick, buzzes for BUZZ_CYC cycles on reaching zero, then waits for a reload.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start, stop   : single-cycle run/pause pulses (stop wins when both high)
//   shoot         : full reload (same effect as reload_full)
//   reload_full   : full reload to RELOAD_FULL
//   reload_short  : raise the count to at least RELOAD_SHORT
//   count         : remaining time (registered)
//   running       : high in RUN
//   expired       : high in BUZZ and EXPIRED
//   buzz          : high in BUZZ (exactly BUZZ_CYC cycles)
//   state_dbg     : current FSM state, for observation only
// Any reload also clears the prescaler and suppresses that cycle's tick.
module shot_clock_ctrl
    import shot_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int RELOAD_FULL  = 24,
    parameter int RELOAD_SHORT = 14,
    parameter int TICK_DIV     = 100,
    parameter int BUZZ_CYC     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             shoot,
    input  logic             reload_full,
    input  logic             reload_short,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             buzz,
    output shot_state_e      state_dbg
);

    localparam int BW = $clog2(BUZZ_CYC + 1);
    localparam logic [CNT_W-1:0] FULL_V  = CNT_W'(RELOAD_FULL);
    localparam logic [CNT_W-1:0] SHORT_V = CNT_W'(RELOAD_SHORT);
    localparam logic [BW-1:0]    BUZZ_LAST = BW'(BUZZ_CYC - 1);

    shot_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [BW-1:0]    buzz_cnt_q, buzz_cnt_d;

    logic             tick;
    logic             full_ld;
    logic             any_ld;
    logic             go;
    logic             rearm;
    logic [CNT_W-1:0] short_cnt;

    assign full_ld   = shoot | reload_full;
    assign any_ld    = full_ld | reload_short;
    assign go        = start & ~stop;
    assign short_cnt = (count_q < SHORT_V) ? SHORT_V : count_q;
    // A short reload that still leaves zero must not leave the expired states.
    assign rearm     = full_ld | (reload_short && (short_cnt != '0));

    shot_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == ST_RUN),
        .clr_i (any_ld),
        .tc_o  (tick)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        buzz_cnt_d = buzz_cnt_q;

        if (full_ld) begin
            count_d = FULL_V;
        end else if (reload_short) begin
            count_d = short_cnt;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_PAUSE: begin
                if (go) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (any_ld) begin
                    if (stop) state_d = ST_PAUSE;
                end else if (tick && (count_q == CNT_W'(1))) begin
                    // The 1->0 decrement enters BUZZ on the same edge.
                    state_d    = ST_BUZZ;
                    buzz_cnt_d = '0;
                end else if (stop) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_BUZZ: begin
                if (rearm) begin
                    state_d = go ? ST_RUN : ST_IDLE;
                end else if (buzz_cnt_q == BUZZ_LAST) begin
                    state_d = ST_EXPIRED;
                end else begin
                    buzz_cnt_d = buzz_cnt_q + 1'b1;
                end
            end
            ST_EXPIRED: begin
                if (rearm) state_d = go ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= FULL_V;
            buzz_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            buzz_cnt_q <= buzz_cnt_d;
        end
    end

    assign count     = count_q;
    assign running   = (state_q == ST_RUN);
    assign buzz      = (state_q == ST_BUZZ);
    assign expired   = (state_q == ST_BUZZ) || (state_q == ST_EXPIRED);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Directed bench for shot_clock_ctrl (CNT_W=4, RELOAD_FULL=5, RELOAD_SHORT=3,
// TICK_DIV=4, BUZZ_CYC=3). Inputs change 1 time unit after a rising edge and
// are sampled by the next rising edge. Each expectation is stamped with the
// cycle (rising-edge count) whose outcome it describes; the monitor compares
// the outputs {count, running, expired, buzz} at the falling edge of that cycle.
module tb_shot_clock_ctrl;
    import shot_pkg::*;

    localparam int W = 7;

    logic        clk = 1'b0;
    logic        rst, start, stop, shoot, reload_full, reload_short;
    logic [3:0]  count;
    logic        running, expired, buzz;
    shot_state_e state_dbg;

    shot_clock_ctrl #(
        .CNT_W(4), .RELOAD_FULL(5), .RELOAD_SHORT(3), .TICK_DIV(4), .BUZZ_CYC(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .shoot(shoot),
        .reload_full(reload_full), .reload_short(reload_short),
        .count(count), .running(running), .expired(expired), .buzz(buzz),
        .state_dbg(state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           cyc_q[$];
    int           tag_q[$];
    int           tst_q[$];
    int           checks = 0;
    int           errors = 0;
    int           tag_n  = 0;
    int           test_n = 0;

    task automatic expect_at(input int dc, input int cnt, input logic run,
                             input logic ex, input logic bz);
        int at;
        int idx;
        at  = cyc + dc;
        idx = cyc_q.size();
        while (idx > 0 && cyc_q[idx-1] > at) idx--;
        cyc_q.insert(idx, at);
        exp_q.insert(idx, {4'(cnt), run, ex, bz});
        tag_q.insert(idx, tag_n);
        tst_q.insert(idx, test_n);
        tag_n++;
    endtask

    // monitor
    logic [W-1:0] m_got, m_exp;
    int           m_cyc, m_tag, m_tst;
    always @(negedge clk) begin
        while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
            m_cyc = cyc_q.pop_front();
            m_exp = exp_q.pop_front();
            m_tag = tag_q.pop_front();
            m_tst = tst_q.pop_front();
            m_got = {count, running, expired, buzz};
            checks++;
            if (m_cyc < cyc) begin
                errors++;
                $display("FAIL t%0d_chk%0d missed: due cyc %0d, seen at cyc %0d",
                         m_tst, m_tag, m_cyc, cyc);
            end else if (m_got !== m_exp) begin
                errors++;
                $display("FAIL t%0d_chk%0d cyc %0d: got cnt=%0d run=%b exp=%b buzz=%b, want cnt=%0d run=%b exp=%b buzz=%b",
                         m_tst, m_tag, cyc, m_got[6:3], m_got[2], m_got[1], m_got[0],
                         m_exp[6:3], m_exp[2], m_exp[1], m_exp[0]);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic st, input logic sp, input logic sh,
                         input logic rf, input logic rs);
        start = st; stop = sp; shoot = sh; reload_full = rf; reload_short = rs;
        step();
        start = 0; stop = 0; shoot = 0; reload_full = 0; reload_short = 0;
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; shoot = 0; reload_full = 0; reload_short = 0;

        // reset state
        test_n = 0;
        repeat (3) step();
        expect_at(0, 5, 0, 0, 0);
        rst = 0;
        step();
        expect_at(0, 5, 0, 0, 0);

        // 1: full countdown, buzz, expired hold
        test_n = 1;
        pulse(1, 0, 0, 0, 0);
        expect_at(0, 5, 1, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            expect_at(4*i - 1, 6 - i, 1, 0, 0);
            expect_at(4*i, 5 - i, i < 5, i == 5, i == 5);
        end
        expect_at(21, 0, 0, 1, 1);
        expect_at(22, 0, 0, 1, 1);
        expect_at(23, 0, 0, 1, 0);
        expect_at(33, 0, 0, 1, 0);
        expect_at(43, 0, 0, 1, 0);
        repeat (43) step();

        // 2: pause mid-tick keeps the prescaler
        test_n = 2;
        pulse(0, 0, 0, 1, 0);
        expect_at(0, 5, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        expect_at(0, 5, 1, 0, 0);
        expect_at(8, 3, 1, 0, 0);
        repeat (9) step();
        pulse(0, 1, 0, 0, 0);
        expect_at(0, 3, 0, 0, 0);
        expect_at(10, 3, 0, 0, 0);
        repeat (10) step();
        pulse(1, 0, 0, 0, 0);
        expect_at(0, 3, 1, 0, 0);
        expect_at(1, 3, 1, 0, 0);
        expect_at(2, 2, 1, 0, 0);

        // 3: reload_short raises 2 -> 3, leaves 4 alone, restarts the tick
        test_n = 3;
        repeat (2) step();
        pulse(0, 0, 0, 0, 1);
        expect_at(0, 3, 1, 0, 0);
        expect_at(3, 3, 1, 0, 0);
        expect_at(4, 2, 1, 0, 0);
        repeat (4) step();
        pulse(0, 0, 1, 0, 0);
        expect_at(0, 5, 1, 0, 0);
        repeat (5) step();
        pulse(0, 0, 0, 0, 1);
        expect_at(0, 4, 1, 0, 0);
        expect_at(3, 4, 1, 0, 0);
        expect_at(4, 3, 1, 0, 0);

        // 4: shoot during buzz, then shoot+start during buzz
        test_n = 4;
        expect_at(16, 0, 0, 1, 1);
        expect_at(17, 0, 0, 1, 1);
        repeat (17) step();
        pulse(0, 0, 1, 0, 0);
        expect_at(0, 5, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        expect_at(20, 0, 0, 1, 1);
        expect_at(21, 0, 0, 1, 1);
        repeat (21) step();
        pulse(1, 0, 1, 0, 0);
        expect_at(0, 5, 1, 0, 0);
        expect_at(3, 5, 1, 0, 0);
        expect_at(4, 4, 1, 0, 0);

        // 5: run-control priorities, start ignored when expired
        test_n = 5;
        repeat (4) step();
        pulse(0, 1, 0, 0, 0);
        expect_at(0, 4, 0, 0, 0);
        pulse(1, 1, 0, 0, 0);
        expect_at(0, 4, 0, 0, 0);
        expect_at(2, 4, 0, 0, 0);
        repeat (2) step();
        pulse(1, 0, 0, 0, 0);
        expect_at(0, 4, 1, 0, 0);
        pulse(0, 1, 1, 0, 0);
        expect_at(0, 5, 0, 0, 0);
        expect_at(5, 5, 0, 0, 0);
        repeat (5) step();
        pulse(1, 0, 0, 0, 0);
        expect_at(23, 0, 0, 1, 0);
        repeat (24) step();
        pulse(1, 0, 0, 0, 0);
        expect_at(0, 0, 0, 1, 0);
        expect_at(2, 0, 0, 1, 0);
        repeat (2) step();

        // 6: asynchronous reset mid-run at count 2
        test_n = 6;
        pulse(0, 0, 1, 0, 0);
        expect_at(0, 5, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        expect_at(12, 2, 1, 0, 0);
        repeat (13) step();
        rst = 1;
        expect_at(0, 5, 0, 0, 0);
        step();
        rst = 0;
        expect_at(0, 5, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        expect_at(0, 5, 1, 0, 0);
        expect_at(4, 4, 1, 0, 0);
        repeat (4) step();

        // drain and report
        repeat (3) step();
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
            checks += exp_q.size();
            errors += exp_q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
